// File: rtl/serial_mux_adder_ctrl.sv
// Bit-serial adder sequencer. One operand bit pair per clock, LSB first,
// through an 8:1-mux full-adder cell; carry recirculates through a flop and
// the sum bits are collected in a right-shifting register.
module serial_mux_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder truth tables, indexed by {a_bit, b_bit, carry}.
  localparam logic [7:0]       SUM_TBL   = 8'b1001_0110;
  localparam logic [7:0]       CARRY_TBL = 8'b1110_1000;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);

  // 8:1 mux cell: the select picks one constant input of the table.
  function automatic logic mux8(input logic [7:0] tbl, input logic [2:0] sel);
    mux8 = tbl[sel];
  endfunction

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;

  logic [2:0]         sel;
  logic               sum_bit;
  logic               carry_bit;

  assign sel       = {a_sh_q[0], b_sh_q[0], carry_q};
  assign sum_bit   = mux8(SUM_TBL, sel);
  assign carry_bit = mux8(CARRY_TBL, sel);

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = {sum_bit, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = carry_bit;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is published on the edge leaving DONE, so done never
        // overlaps busy and a held start is taken on the following edge.
        sum_d   = sum_sh_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_mux_adder_ctrl.sv
// Bench for serial_mux_adder_ctrl (WIDTH=8): directed steps plus a random
// sweep; expected {cout,sum} values queue up at start and are retired on done.
module tb_serial_mux_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic         cin_i;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int e0 = 0;
  logic [W:0] exp_q[$];

  serial_mux_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W:0] exp_of(input logic [W-1:0] av, bv, input logic cv);
    exp_of = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
  endfunction

  // Output monitor: retire scoreboard entries on done, watch busy/done overlap.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      checks++;
      assert (!(busy === 1'b1 && done === 1'b1))
        else begin errors++; $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both 1", busy, done); end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        assert (exp_q.size() != 0)
          else begin errors++; $error("FAIL unexpected_done: observed done=1 expected no pending op"); end
        if (exp_q.size() != 0) begin
          logic [W:0] e;
          e = exp_q.pop_front();
          checks++;
          assert ({cout, sum} === e)
            else begin errors++; $error("FAIL result: observed %h expected %h", {cout, sum}, e); end
        end
      end
    end
  end

  // Called at negedge+1 with the DUT idle; returns one cycle after acceptance.
  task automatic start_op(input logic [W-1:0] av, bv, input logic cv);
    a_i = av; b_i = bv; cin_i = cv; start = 1'b1;
    exp_q.push_back(exp_of(av, bv, cv));
    @(negedge clk); #1;
    start = 1'b0;
    e0 = cyc;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int  n0;
    bit  got;
    n0 = done_cnt;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      if (done_cnt != n0) got = 1'b1;
    end
    checks++;
    assert (got)
      else begin errors++; $error("FAIL %s_timeout: observed no done expected done within 40 cycles", tag); end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, expv); end
  endtask

  initial begin
    int n, d0, d1;
    rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outputs", {28'd0, busy, done, cout, 1'b0}, 32'd0);
    check_val("reset_sum", {24'd0, sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Basic add, latency and busy length
    busy_cnt = 0;
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done("t1");
    check_val("t1_latency", done_cyc - e0, W + 1);
    check_val("t1_busy_cycles", busy_cnt, W);

    // Carry-out corners
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("t2a");
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done("t2b");
    repeat (5) @(negedge clk);
    check_val("t2_hold", {23'd0, cout, sum}, 32'h1FF);

    // Start during RUN is ignored
    n = done_cnt;
    start_op(8'h3C, 8'h0F, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    a_i = 8'h55; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("t3");
    repeat (15) @(negedge clk);
    check_val("t3_one_done", done_cnt - n, 1);

    // Async reset mid-RUN
    a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t4_abort_ctrl", {30'd0, busy, done}, 32'd0);
    check_val("t4_abort_result", {23'd0, cout, sum}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    start_op(8'hAA, 8'h55, 1'b1);
    wait_done("t4_after");

    // Back-to-back with start held high
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start = 1'b1;
    exp_q.push_back(exp_of(8'h12, 8'h34, 1'b0));
    wait_done("t5a");
    d0 = done_cyc;
    a_i = 8'h80; b_i = 8'h90; cin_i = 1'b1;
    exp_q.push_back(exp_of(8'h80, 8'h90, 1'b1));
    wait_done("t5b");
    d1 = done_cyc;
    check_val("t5_spacing_1", d1 - d0, W + 2);
    a_i = 8'hC3; b_i = 8'h3C; cin_i = 1'b1;
    exp_q.push_back(exp_of(8'hC3, 8'h3C, 1'b1));
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("t5c");
    check_val("t5_spacing_2", done_cyc - d1, W + 2);

    // Corners and random sweep
    start_op(8'h00, 8'h00, 1'b0);
    wait_done("t6_zero");
    start_op(8'h80, 8'h80, 1'b0);
    wait_done("t6_msb");
    for (int i = 0; i < 500; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("t6_rand");
    end
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
